// File: rtl/icache_param.sv
// icache_param: blocking set-associative I-cache, true-LRU, fence.i flush.
// Define ICACHE_UNCACHED_EN to fetch addr[31:30]!=0 without allocating.
module icache_param #(
  parameter int NUM_SETS   = 8,
  parameter int NUM_WAYS   = 4,
  parameter int LINE_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        from_cpu_inst_req_valid,
  input  logic [31:0] from_cpu_inst_req_addr,
  output logic        to_cpu_inst_req_ready,
  output logic        to_cpu_cache_rsp_valid,
  output logic [31:0] to_cpu_cache_rsp_data,
  input  logic        from_cpu_cache_rsp_ready,
  input  logic        inv_valid,
  output logic        inv_ready,
  output logic        to_mem_rd_req_valid,
  output logic [31:0] to_mem_rd_req_addr,
  input  logic        from_mem_rd_req_ready,
  input  logic        from_mem_rd_rsp_valid,
  input  logic [31:0] from_mem_rd_rsp_data,
  input  logic        from_mem_rd_rsp_last,
  output logic        to_mem_rd_rsp_ready
);
  localparam int OFF_W = $clog2(LINE_WORDS) + 2;
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 32 - IDX_W - OFF_W;
  localparam int AGE_W = $clog2(NUM_WAYS);
  localparam int WRD_W = $clog2(LINE_WORDS);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, MISS_REQ, REFILL, RESP
  } state_t;

  state_t state_q, state_d;

  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
  logic [31:0]         data_q  [NUM_SETS][NUM_WAYS][LINE_WORDS];
  logic [AGE_W-1:0]    age_q   [NUM_SETS][NUM_WAYS];
  logic [31:0]         line_buf [LINE_WORDS];

  logic [31:2]      req_addr_q;
  logic [31:0]      rsp_data_q;
  logic [WRD_W-1:0] cnt_q;
  logic [AGE_W-1:0] victim_q;

  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] idx;
  logic [WRD_W-1:0] wrd;
  logic             uc;
  logic             unused_ok;

  assign tag = req_addr_q[31 -: TAG_W];
  assign idx = req_addr_q[OFF_W +: IDX_W];
  assign wrd = req_addr_q[2 +: WRD_W];
  assign unused_ok = ^from_cpu_inst_req_addr[1:0];

`ifdef ICACHE_UNCACHED_EN
  assign uc = req_addr_q[31:30] != 2'b00;
`else
  assign uc = 1'b0;
`endif

  logic             hit;
  logic [AGE_W-1:0] hit_way;
  logic [AGE_W-1:0] vic_way;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = AGE_W'(w);
      end
    end
    hit = hit && !uc;
  end

  // Any invalid way beats the oldest; the descending pass keeps the lowest.
  always_comb begin
    vic_way = '0;
    for (int w = 0; w < NUM_WAYS; w++)
      if (age_q[idx][w] == AGE_W'(NUM_WAYS - 1))
        vic_way = AGE_W'(w);
    for (int w = NUM_WAYS - 1; w >= 0; w--)
      if (!valid_q[idx][w])
        vic_way = AGE_W'(w);
  end

  logic             idle;
  logic             req_fire;
  logic             inv_fire;
  logic             beat;
  logic             fill_done;
  logic             lru_upd;
  logic [AGE_W-1:0] upd_way;

  assign idle      = (state_q == IDLE) && !rst;
  assign req_fire  = idle && !inv_valid && from_cpu_inst_req_valid;
  assign inv_fire  = idle && inv_valid;
  assign beat      = (state_q == REFILL) && !rst && from_mem_rd_rsp_valid;
  assign fill_done = beat && from_mem_rd_rsp_last;
  assign lru_upd   = ((state_q == LOOKUP) && hit) || (fill_done && !uc);
  assign upd_way   = (state_q == LOOKUP) ? hit_way : victim_q;

  assign to_cpu_inst_req_ready  = idle && !inv_valid;
  assign inv_ready              = idle;
  assign to_mem_rd_rsp_ready    = idle || ((state_q == REFILL) && !rst);
  assign to_mem_rd_req_valid    = (state_q == MISS_REQ) && !rst;
  assign to_cpu_cache_rsp_valid = (state_q == RESP) && !rst;

  assign to_mem_rd_req_addr = to_mem_rd_req_valid ?
    {req_addr_q[31:OFF_W], {OFF_W{1'b0}}} : '0;
  assign to_cpu_cache_rsp_data = to_cpu_cache_rsp_valid ?
    rsp_data_q : '0;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (req_fire) state_d = LOOKUP;
      LOOKUP:   state_d = hit ? RESP : MISS_REQ;
      MISS_REQ: if (from_mem_rd_req_ready) state_d = REFILL;
      REFILL:   if (fill_done) state_d = RESP;
      RESP:     if (from_cpu_cache_rsp_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++)
          age_q[s][w] <= AGE_W'(w);
      end
    end else begin
      if (inv_fire)
        for (int s = 0; s < NUM_SETS; s++)
          valid_q[s] <= '0;
      if (beat)
        cnt_q <= fill_done ? '0 : cnt_q + 1'b1;
      if (fill_done && !uc)
        valid_q[idx][victim_q] <= 1'b1;
      if (lru_upd) begin
        for (int w = 0; w < NUM_WAYS; w++)
          if (age_q[idx][w] < age_q[idx][upd_way])
            age_q[idx][w] <= age_q[idx][w] + 1'b1;
        age_q[idx][upd_way] <= '0;
      end
    end
  end

  // The final beat bypasses line_buf so the line lands in the same cycle.
  always_ff @(posedge clk) begin
    if (req_fire)
      req_addr_q <= from_cpu_inst_req_addr[31:2];
    if (state_q == LOOKUP) begin
      victim_q <= vic_way;
      if (hit) rsp_data_q <= data_q[idx][hit_way][wrd];
    end
    if (beat) begin
      if (!uc) line_buf[cnt_q] <= from_mem_rd_rsp_data;
      if (cnt_q == wrd) rsp_data_q <= from_mem_rd_rsp_data;
    end
    if (fill_done && !uc) begin
      tag_q[idx][victim_q] <= tag;
      for (int i = 0; i < LINE_WORDS; i++)
        data_q[idx][victim_q][i] <= (WRD_W'(i) == cnt_q) ?
          from_mem_rd_rsp_data : line_buf[i];
    end
  end
endmodule

// File: tb/tb_icache_param.sv
// tb_icache_param: vector table, corner sequences and random fetches
// checked against a recency-list cache model.
module tb_icache_param;
  localparam int NUM_SETS   = 8;
  localparam int NUM_WAYS   = 4;
  localparam int LINE_WORDS = 8;
  localparam int LINE_BYTES = LINE_WORDS * 4;
  localparam int NV         = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_ready = 1'b0;
  logic        inv_valid = 1'b0;
  logic        inv_ready;
  logic        rd_req_valid;
  logic [31:0] rd_req_addr;
  logic        rd_req_ready = 1'b0;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        mem_rsp_last = 1'b0;
  logic        mem_rsp_ready;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  icache_param #(
    .NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS), .LINE_WORDS(LINE_WORDS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .from_cpu_inst_req_valid(req_valid),
    .from_cpu_inst_req_addr(req_addr),
    .to_cpu_inst_req_ready(req_ready),
    .to_cpu_cache_rsp_valid(rsp_valid),
    .to_cpu_cache_rsp_data(rsp_data),
    .from_cpu_cache_rsp_ready(rsp_ready),
    .inv_valid(inv_valid),
    .inv_ready(inv_ready),
    .to_mem_rd_req_valid(rd_req_valid),
    .to_mem_rd_req_addr(rd_req_addr),
    .from_mem_rd_req_ready(rd_req_ready),
    .from_mem_rd_rsp_valid(mem_rsp_valid),
    .from_mem_rd_rsp_data(mem_rsp_data),
    .from_mem_rd_rsp_last(mem_rsp_last),
    .to_mem_rd_rsp_ready(mem_rsp_ready)
  );

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  // Memory image: every word holds a value unique to its address.
  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a >> 2) - 32'h3F0;
  endfunction

  // Reference: per set, resident line addresses ordered most recent first.
  logic [31:0] rec [NUM_SETS][NUM_WAYS];
  int          n   [NUM_SETS];

  function automatic void model_clear();
    for (int s = 0; s < NUM_SETS; s++) n[s] = 0;
  endfunction

  function automatic bit model_access(logic [31:0] a);
    logic [31:0] line;
    int s, pos;
    bit miss;
`ifdef ICACHE_UNCACHED_EN
    if (a[31:30] != 2'b00) return 1'b1;
`endif
    line = a & ~32'(LINE_BYTES - 1);
    s    = int'((a / LINE_BYTES) % NUM_SETS);
    pos  = -1;
    for (int i = 0; i < n[s]; i++)
      if (rec[s][i] == line) pos = i;
    miss = (pos < 0);
    if (miss) begin
      if (n[s] < NUM_WAYS) n[s]++;
      pos = n[s] - 1;
    end
    for (int i = pos; i > 0; i--) rec[s][i] = rec[s][i-1];
    rec[s][0] = line;
    return miss;
  endfunction

  task automatic do_inv();
    @(negedge clk);
    inv_valid = 1'b1;
    #1 chk("inv_ready", inv_ready, 1);
    @(negedge clk);
    inv_valid = 1'b0;
  endtask

  // One complete fetch, acting as CPU and memory; jitter adds stalls.
  task automatic fetch(input logic [31:0] a, input int last_at,
                       input bit jitter, output logic [31:0] d,
                       output bit miss, output logic [31:0] maddr,
                       output int lat, output int mlat, output int gap);
    int c0, beat, last_cyc;
    bit phase, refill, done;
    d = '0; miss = 0; maddr = '0; lat = -1; mlat = -1; gap = -1;
    c0 = 0; beat = 0; last_cyc = 0; phase = 0; refill = 0; done = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      req_valid     = !phase;
      req_addr      = a;
      rd_req_ready  = 1'b0;
      rsp_ready     = 1'b0;
      mem_rsp_valid = refill && (!jitter || $urandom_range(2) != 0);
      mem_rsp_data  = mem_word(maddr + 32'(beat * 4));
      mem_rsp_last  = mem_rsp_valid && (beat == last_at);
      #1;
      if (!phase) begin
        if (req_ready) begin
          phase = 1;
          c0    = cyc;
        end
      end else begin
        if (refill && mem_rsp_valid && mem_rsp_ready) begin
          if (mem_rsp_last) begin
            refill   = 0;
            last_cyc = cyc;
          end
          beat++;
        end
        if (rd_req_valid && !refill) begin
          if (!miss) begin
            miss  = 1;
            maddr = rd_req_addr;
            mlat  = cyc - c0;
          end
          rd_req_ready = !jitter || $urandom_range(1) == 1;
          if (rd_req_ready) refill = 1;
        end
        if (rsp_valid) begin
          if (lat < 0) begin
            d   = rsp_data;
            lat = cyc - c0;
            gap = cyc - last_cyc;
          end
          rsp_ready = !jitter || $urandom_range(1) == 1;
          if (rsp_ready) done = 1;
        end
      end
    end
    chk("fetch_done", 32'(done), 1);
    @(negedge clk);
    req_valid     = 1'b0;
    rsp_ready     = 1'b0;
    rd_req_ready  = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_last  = 1'b0;
  endtask

  typedef struct {
    bit          inv;
    logic [31:0] addr;
    bit          miss;
    logic [31:0] maddr;
    logic [31:0] data;
  } vec_t;

  vec_t vt [NV];

  initial begin
    #500_000;
    $display("FAIL watchdog: cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, ma, a, d0;
    bit m, em, ok;
    int lat, mlat, gap;

    vt[0]  = '{0, 32'h1004, 1, 32'h1000, 32'h11};
    vt[1]  = '{0, 32'h1004, 0, 32'h0,    32'h11};
    vt[2]  = '{1, 32'h0000, 1, 32'h0000, mem_word(32'h0000)};
    vt[3]  = '{0, 32'h0100, 1, 32'h0100, mem_word(32'h0100)};
    vt[4]  = '{0, 32'h0200, 1, 32'h0200, mem_word(32'h0200)};
    vt[5]  = '{0, 32'h0300, 1, 32'h0300, mem_word(32'h0300)};
    vt[6]  = '{0, 32'h0400, 1, 32'h0400, mem_word(32'h0400)};
    vt[7]  = '{0, 32'h0000, 1, 32'h0000, mem_word(32'h0000)};
    vt[8]  = '{0, 32'h021C, 0, 32'h0,    mem_word(32'h021C)};
    vt[9]  = '{0, 32'h0104, 1, 32'h0100, mem_word(32'h0104)};
    vt[10] = '{0, 32'h0408, 0, 32'h0,    mem_word(32'h0408)};
    vt[11] = '{0, 32'h0310, 1, 32'h0300, mem_word(32'h0310)};

    repeat (2) @(negedge clk);
    #1;
    chk("rst req_ready", req_ready, 0);
    chk("rst inv_ready", inv_ready, 0);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst rsp_data", rsp_data, 0);
    chk("rst rd_req_valid", rd_req_valid, 0);
    chk("rst rd_req_addr", rd_req_addr, 0);
    chk("rst mem_rsp_ready", mem_rsp_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle req_ready", req_ready, 1);
    chk("idle inv_ready", inv_ready, 1);
    chk("idle mem_rsp_ready", mem_rsp_ready, 1);

    for (int i = 0; i < NV; i++) begin
      if (vt[i].inv) do_inv();
      fetch(vt[i].addr, LINE_WORDS - 1, 0, d, m, ma, lat, mlat, gap);
      chk($sformatf("vec%0d miss", i), 32'(m), 32'(vt[i].miss));
      chk($sformatf("vec%0d data", i), d, vt[i].data);
      if (vt[i].miss) begin
        chk($sformatf("vec%0d rd_addr", i), ma, vt[i].maddr);
        chk($sformatf("vec%0d req_lat", i), 32'(mlat), 2);
        chk($sformatf("vec%0d last_gap", i), 32'(gap), 1);
      end else begin
        chk($sformatf("vec%0d hit_lat", i), 32'(lat), 2);
      end
    end

    fetch(32'h3004, 3, 0, d, m, ma, lat, mlat, gap);
    chk("early_last miss", 32'(m), 1);
    chk("early_last data", d, mem_word(32'h3004));
    fetch(32'h300C, LINE_WORDS - 1, 0, d, m, ma, lat, mlat, gap);
    chk("early_last hit", 32'(m), 0);
    chk("early_last word3", d, mem_word(32'h300C));

    fetch(32'h1004, LINE_WORDS - 1, 0, d, m, ma, lat, mlat, gap);
    fetch(32'h1004, LINE_WORDS - 1, 0, d, m, ma, lat, mlat, gap);
    chk("inv_pre hit", 32'(m), 0);
    @(negedge clk);
    inv_valid = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h1004;
    #1;
    chk("inv+req inv_ready", inv_ready, 1);
    chk("inv+req req_ready", req_ready, 0);
    @(negedge clk);
    inv_valid = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("inv+req still idle", req_ready, 1);
    chk("inv+req no rsp", rsp_valid, 0);
    fetch(32'h1004, LINE_WORDS - 1, 0, d, m, ma, lat, mlat, gap);
    chk("inv_post miss", 32'(m), 1);
    chk("inv_post data", d, 32'h11);

    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h1004;
    #1 chk("hold accept", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("hold rsp_valid", rsp_valid, 1);
    d0 = rsp_data;
    chk("hold data", d0, 32'h11);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_addr  = 32'h1008;
      #1;
      chk($sformatf("hold%0d valid", i), rsp_valid, 1);
      chk($sformatf("hold%0d data", i), rsp_data, d0);
      chk($sformatf("hold%0d req_ready", i), req_ready, 0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    #1 chk("hold final valid", rsp_valid, 1);
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk("hold release ready", req_ready, 1);
    chk("hold release valid", rsp_valid, 0);
    chk("hold release data", rsp_data, 0);

    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h2008;
    #1 chk("rstmid accept", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    ok = 0;
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge clk);
      #1 ok = rd_req_valid;
    end
    chk("rstmid rd_req", 32'(ok), 1);
    rd_req_ready = 1'b1;
    @(negedge clk);
    rd_req_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mem_word(32'h2000 + 32'(b * 4));
      mem_rsp_last  = 1'b0;
      #1 chk($sformatf("rstmid beat%0d", b), mem_rsp_ready, 1);
      @(negedge clk);
    end
    mem_rsp_data = mem_word(32'h2008);
    rst = 1'b1;
    #1;
    chk("rstmid req_ready", req_ready, 0);
    chk("rstmid inv_ready", inv_ready, 0);
    chk("rstmid mem_rsp_ready", mem_rsp_ready, 0);
    chk("rstmid rd_req_valid", rd_req_valid, 0);
    chk("rstmid rsp_valid", rsp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    for (int b = 2; b < LINE_WORDS; b++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mem_word(32'h2000 + 32'(b * 4));
      mem_rsp_last  = (b == LINE_WORDS - 1);
      #1;
      chk($sformatf("drain%0d ready", b), mem_rsp_ready, 1);
      chk($sformatf("drain%0d no rsp", b), rsp_valid, 0);
      @(negedge clk);
    end
    mem_rsp_valid = 1'b0;
    mem_rsp_last  = 1'b0;
    #1;
    chk("drain idle", req_ready, 1);
    chk("drain no rd_req", rd_req_valid, 0);
    fetch(32'h2008, LINE_WORDS - 1, 0, d, m, ma, lat, mlat, gap);
    chk("rstmid refetch miss", 32'(m), 1);
    chk("rstmid refetch addr", ma, 32'h2000);
    chk("rstmid refetch data", d, mem_word(32'h2008));

`ifdef ICACHE_UNCACHED_EN
    for (int i = 0; i < 2; i++) begin
      fetch(32'hC000_0008, LINE_WORDS - 1, 0, d, m, ma, lat, mlat, gap);
      chk($sformatf("uc%0d miss", i), 32'(m), 1);
      chk($sformatf("uc%0d addr", i), ma, 32'hC000_0000);
      chk($sformatf("uc%0d data", i), d, mem_word(32'hC000_0008));
      chk($sformatf("uc%0d gap", i), 32'(gap), 1);
    end
`endif

    do_inv();
    model_clear();
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(9) == 0) begin
        do_inv();
        model_clear();
      end else begin
        a = (32'($urandom_range(5)) << 8) | (32'($urandom_range(1)) << 5)
          | (32'($urandom_range(LINE_WORDS - 1)) << 2);
`ifdef ICACHE_UNCACHED_EN
        if ($urandom_range(7) == 0) a[31:30] = 2'b11;
`endif
        em = model_access(a);
        fetch(a, LINE_WORDS - 1, 1, d, m, ma, lat, mlat, gap);
        chk($sformatf("rnd%0d %h miss", t, a), 32'(m), 32'(em));
        chk($sformatf("rnd%0d %h data", t, a), d, mem_word(a));
        if (em) begin
          chk($sformatf("rnd%0d rd_addr", t), ma,
              a & ~32'(LINE_BYTES - 1));
          chk($sformatf("rnd%0d last_gap", t), 32'(gap), 1);
        end else begin
          chk($sformatf("rnd%0d hit_lat", t), 32'(lat), 2);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
